// File: rtl/m1_yuv_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : m1_yuv_to_rgb
// Purpose  : Reads a YUV 4:2:2 frame from SRAM, replicates chroma horizontally,
//            converts each pixel to RGB and writes packed 8-bit RGB back.
// Revision : 1.0 - initial release
// ============================================================================
module m1_yuv_to_rgb #(
    parameter logic [17:0] Y_BASE     = 18'd0,
    parameter logic [17:0] U_BASE     = 18'd38400,
    parameter logic [17:0] V_BASE     = 18'd57600,
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [14:0] NUM_GROUPS = 15'd19200
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        M1_start,
    output logic        M1_stop,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_Y0  = 4'd1,
        S_RD_Y1  = 4'd2,
        S_RD_U   = 4'd3,
        S_RD_V   = 4'd4,
        S_W0     = 4'd5,
        S_W1     = 4'd6,
        S_CALC_A = 4'd7,
        S_WR0    = 4'd8,
        S_WR1    = 4'd9,
        S_WR2    = 4'd10,
        S_CALC_B = 4'd11,
        S_WR3    = 4'd12,
        S_WR4    = 4'd13,
        S_WR5    = 4'd14,
        S_DONE   = 4'd15
    } t_state;

    t_state      r_state;
    t_state      w_next_state;
    logic        r_start_d;
    logic [14:0] r_group;
    logic [14:0] w_next_group;
    logic [15:0] r_y0;
    logic [15:0] r_y1;
    logic [15:0] r_u;
    logic [15:0] r_v;
    logic [17:0] r_wr_ptr;
    logic [7:0]  r_b_a;
    logic [23:0] r_rgb_b;

    logic [17:0] w_addr;
    logic [15:0] w_wdata;
    logic        w_we_n;
    logic        w_stop;
    logic [15:0] w_y_word;
    logic [7:0]  w_u;
    logic [7:0]  w_v;
    logic [23:0] w_rgb_a;
    logic [23:0] w_rgb_b;
    logic        w_last_group;

    function automatic logic [7:0] clip(input logic signed [31:0] s);
        if (s[31])
            return 8'd0;
        else if (|s[30:24])
            return 8'd255;
        else
            return s[23:16];
    endfunction

    function automatic logic [23:0] csc(input logic [7:0] y, input logic [7:0] u,
                                        input logic [7:0] v);
        logic signed [31:0] ys;
        logic signed [31:0] us;
        logic signed [31:0] vs;
        ys = $signed({24'd0, y}) - 32'sd16;
        us = $signed({24'd0, u}) - 32'sd128;
        vs = $signed({24'd0, v}) - 32'sd128;
        return {clip(32'sd76284 * ys + 32'sd104595 * vs),
                clip(32'sd76284 * ys - 32'sd25624 * us - 32'sd53281 * vs),
                clip(32'sd76284 * ys + 32'sd132251 * us)};
    endfunction

    // CALC_A works on pixels 0,1 (high chroma bytes), CALC_B on pixels 2,3.
    always_comb begin
        w_y_word = r_y1;
        w_u      = r_u[7:0];
        w_v      = r_v[7:0];
        if (r_state == S_CALC_A) begin
            w_y_word = r_y0;
            w_u      = r_u[15:8];
            w_v      = r_v[15:8];
        end
    end

    assign w_rgb_a      = csc(w_y_word[15:8], w_u, w_v);
    assign w_rgb_b      = csc(w_y_word[7:0], w_u, w_v);
    assign w_last_group = (r_group == NUM_GROUPS - 15'd1);

    always_comb begin
        w_next_state = r_state;
        w_next_group = r_group;
        case (r_state)
            S_IDLE:   if (M1_start && !r_start_d) w_next_state = S_RD_Y0;
            S_RD_Y0:  w_next_state = S_RD_Y1;
            S_RD_Y1:  w_next_state = S_RD_U;
            S_RD_U:   w_next_state = S_RD_V;
            S_RD_V:   w_next_state = S_W0;
            S_W0:     w_next_state = S_W1;
            S_W1:     w_next_state = S_CALC_A;
            S_CALC_A: w_next_state = S_WR0;
            S_WR0:    w_next_state = S_WR1;
            S_WR1:    w_next_state = S_WR2;
            S_WR2:    w_next_state = S_CALC_B;
            S_CALC_B: w_next_state = S_WR3;
            S_WR3:    w_next_state = S_WR4;
            S_WR4:    w_next_state = S_WR5;
            S_WR5: begin
                if (w_last_group) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RD_Y0;
                    w_next_group = r_group + 15'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_next_group = 15'd0;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_addr  = SRAM_address;
        w_wdata = SRAM_write_data;
        w_we_n  = 1'b1;
        w_stop  = 1'b0;
        case (w_next_state)
            S_RD_Y0: w_addr = Y_BASE + {2'b00, w_next_group, 1'b0};
            S_RD_Y1: w_addr = Y_BASE + {2'b00, w_next_group, 1'b1};
            S_RD_U:  w_addr = U_BASE + {3'b000, w_next_group};
            S_RD_V:  w_addr = V_BASE + {3'b000, w_next_group};
            S_WR0, S_WR3: begin
                w_addr  = r_wr_ptr;
                w_we_n  = 1'b0;
                w_wdata = {w_rgb_a[23:16], w_rgb_a[15:8]};
            end
            S_WR1, S_WR4: begin
                w_addr  = r_wr_ptr;
                w_we_n  = 1'b0;
                w_wdata = {r_b_a, r_rgb_b[23:16]};
            end
            S_WR2, S_WR5: begin
                w_addr  = r_wr_ptr;
                w_we_n  = 1'b0;
                w_wdata = {r_rgb_b[15:8], r_rgb_b[7:0]};
            end
            S_DONE:  w_stop = 1'b1;
            default: w_stop = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= S_IDLE;
            r_start_d       <= 1'b0;
            r_group         <= 15'd0;
            r_wr_ptr        <= RGB_BASE;
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            M1_stop         <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_start_d       <= M1_start;
            r_group         <= w_next_group;
            SRAM_address    <= w_addr;
            SRAM_write_data <= w_wdata;
            SRAM_we_n       <= w_we_n;
            M1_stop         <= w_stop;
            if (r_state == S_IDLE && w_next_state == S_RD_Y0)
                r_wr_ptr <= RGB_BASE;
            else if (!w_we_n)
                r_wr_ptr <= r_wr_ptr + 18'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_y0    <= 16'd0;
            r_y1    <= 16'd0;
            r_u     <= 16'd0;
            r_v     <= 16'd0;
            r_b_a   <= 8'd0;
            r_rgb_b <= 24'd0;
        end else begin
            case (r_state)
                S_RD_U:   r_y0 <= SRAM_read_data;
                S_RD_V:   r_y1 <= SRAM_read_data;
                S_W0:     r_u  <= SRAM_read_data;
                S_W1:     r_v  <= SRAM_read_data;
                S_CALC_A, S_CALC_B: begin
                    r_b_a   <= w_rgb_a[7:0];
                    r_rgb_b <= w_rgb_b;
                end
                default:  r_y0 <= r_y0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m1_yuv_to_rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_m1_yuv_to_rgb
// Purpose  : Self-checking bench for m1_yuv_to_rgb against a pixel-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m1_yuv_to_rgb;

    localparam int N   = 40;
    localparam int YB  = 0;
    localparam int UB  = 38400;
    localparam int VB  = 57600;
    localparam int RB  = 262144 - 6 * N;
    localparam int NW  = 6 * N;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        M1_start = 1'b0;
    logic        M1_stop;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    m1_yuv_to_rgb #(
        .Y_BASE     (18'(YB)),
        .U_BASE     (18'(UB)),
        .V_BASE     (18'(VB)),
        .RGB_BASE   (18'(RB)),
        .NUM_GROUPS (15'(N))
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .M1_start        (M1_start),
        .M1_stop         (M1_stop),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    always #10 Clock = ~Clock;

    // SRAM: read data appears two clocks after the address.
    logic [15:0] mem [0:262143];
    logic [15:0] q1 = 16'd0;
    logic [15:0] q2 = 16'd0;
    always @(posedge Clock) begin
        q1 <= mem[SRAM_address];
        q2 <= q1;
    end
    assign SRAM_read_data = q2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stop_cnt = 0;
    int stop_cyc = 0;
    logic [17:0] cap_addr [$];
    logic [15:0] cap_data [$];
    logic [15:0] exp_w [0:NW-1];

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Resetn) begin
            if (!SRAM_we_n) begin
                cap_addr.push_back(SRAM_address);
                cap_data.push_back(SRAM_write_data);
            end
            if (M1_stop) begin
                stop_cnt <= stop_cnt + 1;
                stop_cyc <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clip8(input int s);
        if (s < 0) return 0;
        if (s >= 16777216) return 255;
        return s / 65536;
    endfunction

    // Expand to a per-pixel RGB byte stream, then pack two bytes per word.
    task automatic build_expected();
        byte unsigned stream [0:12*N-1];
        for (int p = 0; p < 4 * N; p++) begin
            int yw, uw, vw, y, u, v;
            yw = int'(mem[YB + p / 2]);
            uw = int'(mem[UB + p / 4]);
            vw = int'(mem[VB + p / 4]);
            y  = (p % 2 == 0) ? (yw >> 8) : (yw & 255);
            u  = (p % 4 < 2) ? (uw >> 8) : (uw & 255);
            v  = (p % 4 < 2) ? (vw >> 8) : (vw & 255);
            y  = y - 16;
            u  = u - 128;
            v  = v - 128;
            stream[3*p]   = 8'(clip8(76284 * y + 104595 * v));
            stream[3*p+1] = 8'(clip8(76284 * y - 25624 * u - 53281 * v));
            stream[3*p+2] = 8'(clip8(76284 * y + 132251 * u));
        end
        for (int k = 0; k < NW; k++)
            exp_w[k] = {stream[2*k], stream[2*k+1]};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2 * N; i++) mem[YB + i] = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            mem[UB + i] = 16'($urandom);
            mem[VB + i] = 16'($urandom);
        end
    endtask

    task automatic set_group0(input logic [15:0] y0, input logic [15:0] y1,
                              input logic [15:0] u, input logic [15:0] v);
        mem[YB] = y0;
        mem[YB + 1] = y1;
        mem[UB] = u;
        mem[VB] = v;
    endtask

    task automatic run_full(input string tag, output int base_w);
        int base_s, t0, got_n;
        build_expected();
        @(negedge Clock);
        M1_start = 1'b0;
        @(negedge Clock);
        base_w = cap_addr.size();
        base_s = stop_cnt;
        M1_start = 1'b1;
        t0 = cyc + 1;
        @(negedge Clock);
        check({tag, ":first_addr"}, 32'(SRAM_address), YB);
        for (int i = 0; i < 14 * N + 40 && stop_cnt == base_s; i++) @(posedge Clock);
        check({tag, ":done_seen"}, 32'(stop_cnt != base_s), 1);
        repeat (5) @(negedge Clock);
        check({tag, ":stop_pulses"}, stop_cnt - base_s, 1);
        check({tag, ":latency"}, stop_cyc - t0, 14 * N);
        got_n = cap_addr.size() - base_w;
        check({tag, ":write_count"}, got_n, NW);
        for (int k = 0; k < NW && k < got_n; k++) begin
            check($sformatf("%s:addr[%0d]", tag, k), 32'(cap_addr[base_w + k]), RB + k);
            check($sformatf("%s:data[%0d]", tag, k), 32'(cap_data[base_w + k]), 32'(exp_w[k]));
        end
        if (got_n == NW)
            check({tag, ":last_addr"}, 32'(cap_addr[base_w + NW - 1]), 262143);
    endtask

    initial begin
        int b, wb, sb;
        bit found;

        repeat (3) @(negedge Clock);
        check("rst:we_n", 32'(SRAM_we_n), 1);
        check("rst:addr", 32'(SRAM_address), 0);
        check("rst:wdata", 32'(SRAM_write_data), 0);
        check("rst:stop", 32'(M1_stop), 0);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check("idle:we_n", 32'(SRAM_we_n), 1);
        check("idle:addr", 32'(SRAM_address), 0);

        fill_random();
        set_group0(16'h1010, 16'h1010, 16'h8080, 16'h8080);
        run_full("black", b);
        for (int k = 0; k < 6; k++)
            if (b + k < cap_data.size())
                check($sformatf("black:word%0d", k), 32'(cap_data[b + k]), 32'h0000);

        fill_random();
        set_group0(16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
        run_full("white", b);
        for (int k = 0; k < 6; k++)
            if (b + k < cap_data.size())
                check($sformatf("white:word%0d", k), 32'(cap_data[b + k]), 32'hFEFE);

        fill_random();
        set_group0(16'hFF00, 16'h1010, 16'h8080, 16'hFF80);
        run_full("clip", b);
        if (b + 2 < cap_data.size()) begin
            check("clip:word0", 32'(cap_data[b]), 32'hFFAE);
            check("clip:word2", 32'(cap_data[b + 2]), 32'h0000);
        end

        for (int r = 0; r < 2; r++) begin
            fill_random();
            run_full($sformatf("rand%0d", r), b);
        end

        // Start stays high: no retrigger, then a fresh edge restarts.
        wb = cap_addr.size();
        sb = stop_cnt;
        repeat (1000) @(negedge Clock);
        check("hold:no_writes", cap_addr.size() - wb, 0);
        check("hold:no_stop", stop_cnt - sb, 0);
        fill_random();
        run_full("restart", b);

        // Abort during the second write of group 5.
        fill_random();
        @(negedge Clock);
        M1_start = 1'b0;
        @(negedge Clock);
        M1_start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 14 * N + 40 && !found; i++) begin
            @(negedge Clock);
            if (!SRAM_we_n && SRAM_address == 18'(RB + 31)) found = 1'b1;
        end
        check("abort:reached_wr1", 32'(found), 1);
        Resetn = 1'b0;
        M1_start = 1'b0;
        #1;
        check("abort:we_n", 32'(SRAM_we_n), 1);
        check("abort:addr", 32'(SRAM_address), 0);
        check("abort:wdata", 32'(SRAM_write_data), 0);
        check("abort:stop", 32'(M1_stop), 0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        wb = cap_addr.size();
        sb = stop_cnt;
        repeat (50) @(negedge Clock);
        check("abort:no_writes", cap_addr.size() - wb, 0);
        check("abort:no_stop", stop_cnt - sb, 0);
        run_full("rerun", b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout got=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
